// File: rtl/pipe_elastic_fifo.sv
// Elastic DEPTH-entry circular queue between pipeline stages.
// All handshake outputs are registered; o_data comes straight from storage.
module pipe_elastic_fifo #(
    parameter int DWIDTH      = 8,
    parameter int DEPTH       = 4,
    parameter int AFULL_LEVEL = DEPTH - 1,
    localparam int CW         = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic [DWIDTH-1:0] i_data,
    input  logic              i_valid,
    output logic              o_ready,
    output logic [DWIDTH-1:0] o_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [CW-1:0]     o_count,
    output logic              o_almost_full
);

    localparam int PW = $clog2(DEPTH);

    logic [DWIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_inc;
    logic [PW-1:0]     rd_inc;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     cnt_next;
    logic              push;
    logic              pop;

    // Transfer qualification, next occupancy and wrapped pointer increments
    always_comb begin
        push     = i_valid & o_ready;
        pop      = o_valid & i_ready;
        cnt_next = cnt + CW'(push) - CW'(pop);
        wr_inc   = (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
        rd_inc   = (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
    end

    // Payload storage; flush leaves contents alone but blocks the write
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push && !flush) begin
            mem[wr_ptr] <= i_data;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_inc;
            end
            if (pop) begin
                rd_ptr <= rd_inc;
            end
            cnt <= cnt_next;
        end
    end

    // Registered handshake flags computed from the post-transfer occupancy
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            o_valid       <= 1'b0;
            o_ready       <= 1'b0;
            o_almost_full <= 1'b0;
        end else if (flush) begin
            o_valid       <= 1'b0;
            o_ready       <= 1'b1;
            o_almost_full <= 1'b0;
        end else begin
            o_valid       <= (cnt_next != '0);
            o_ready       <= (cnt_next < CW'(DEPTH));
            o_almost_full <= (cnt_next >= CW'(AFULL_LEVEL));
        end
    end

    assign o_data  = mem[rd_ptr];
    assign o_count = cnt;

endmodule

// File: tb/tb_pipe_elastic_fifo.sv
// Directed bench for pipe_elastic_fifo: DEPTH=4 instance for the main
// scenarios, DEPTH=3 instance for pointer wrap and mid-stream reset.
module tb_pipe_elastic_fifo;

    logic       clk;
    logic       reset_n;
    logic       flush;
    logic [7:0] i_data;
    logic       i_valid;
    logic       o_ready;
    logic [7:0] o_data;
    logic       o_valid;
    logic       i_ready;
    logic [2:0] o_count;
    logic       o_almost_full;

    logic       rst3_n;
    logic       flush3;
    logic [7:0] d3;
    logic       v3;
    logic       rdy3;
    logic [7:0] q3;
    logic       vo3;
    logic       r3;
    logic [1:0] cnt3;
    logic       af3;

    int vectors = 0;
    int miscompares = 0;

    pipe_elastic_fifo #(.DWIDTH(8), .DEPTH(4), .AFULL_LEVEL(3)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .flush(flush),
        .i_data(i_data),
        .i_valid(i_valid),
        .o_ready(o_ready),
        .o_data(o_data),
        .o_valid(o_valid),
        .i_ready(i_ready),
        .o_count(o_count),
        .o_almost_full(o_almost_full)
    );

    pipe_elastic_fifo #(.DWIDTH(8), .DEPTH(3), .AFULL_LEVEL(2)) dut3 (
        .clk(clk),
        .reset_n(rst3_n),
        .flush(flush3),
        .i_data(d3),
        .i_valid(v3),
        .o_ready(rdy3),
        .o_data(q3),
        .o_valid(vo3),
        .i_ready(r3),
        .o_count(cnt3),
        .o_almost_full(af3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0]  sb[$];
        logic [11:0] pv;
        logic [11:0] pr;
        logic        psh;
        logic        pp;
        logic [7:0]  dv;

        reset_n = 1'b1;
        rst3_n  = 1'b1;
        flush   = 1'b0;
        i_data  = 8'h00;
        i_valid = 1'b0;
        i_ready = 1'b0;
        flush3  = 1'b0;
        d3      = 8'h00;
        v3      = 1'b0;
        r3      = 1'b0;
        #1;
        reset_n = 1'b0;
        rst3_n  = 1'b0;
        #1;

        // 1. reset state
        chk("rst_ready", o_ready, 0);
        chk("rst_valid", o_valid, 0);
        chk("rst_count", o_count, 0);
        chk("rst_afull", o_almost_full, 0);
        chk("rst_data", o_data, 0);
        step();
        chk("rst_ready_held", o_ready, 0);
        reset_n = 1'b1;
        rst3_n  = 1'b1;
        step();
        chk("post_rst_ready", o_ready, 1);
        chk("post_rst_count", o_count, 0);
        chk("post_rst_valid", o_valid, 0);

        // 2. streaming
        i_valid = 1'b1;
        i_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            i_data = 8'(i);
            step();
            chk("stream_valid", o_valid, 1);
            chk("stream_data", o_data, i);
            chk("stream_count", o_count, 1);
        end
        i_valid = 1'b0;
        step();
        chk("stream_end_valid", o_valid, 0);
        chk("stream_end_count", o_count, 0);

        // 3. fill and backpressure
        i_ready = 1'b0;
        i_valid = 1'b1;
        i_data  = 8'hA0;
        step();
        i_data  = 8'hA1;
        step();
        chk("fill2_afull", o_almost_full, 0);
        i_data  = 8'hA2;
        step();
        chk("fill3_afull", o_almost_full, 1);
        chk("fill3_ready", o_ready, 1);
        i_data  = 8'hA3;
        step();
        chk("full_count", o_count, 4);
        chk("full_ready", o_ready, 0);
        chk("full_head", o_data, 8'hA0);
        i_data  = 8'hA4;
        step();
        chk("held_count", o_count, 4);
        chk("held_ready", o_ready, 0);
        i_ready = 1'b1;
        step();
        chk("pop1_ready", o_ready, 1);
        chk("pop1_count", o_count, 3);
        chk("pop1_head", o_data, 8'hA1);
        i_ready = 1'b0;
        step();
        chk("a4_count", o_count, 4);
        i_valid = 1'b0;
        i_ready = 1'b1;
        chk("drain_a1", o_data, 8'hA1);
        step();
        chk("drain_a2", o_data, 8'hA2);
        step();
        chk("drain_a3", o_data, 8'hA3);
        step();
        chk("drain_a4", o_data, 8'hA4);
        chk("drain_a4_count", o_count, 1);
        step();
        chk("drained_valid", o_valid, 0);
        chk("drained_afull", o_almost_full, 0);

        // 4. full with simultaneous pop and offered push
        i_ready = 1'b0;
        i_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            i_data = 8'(8'hB0 + i);
            step();
        end
        chk("b_full_count", o_count, 4);
        i_data  = 8'hB4;
        i_ready = 1'b1;
        step();
        chk("b_pop_count", o_count, 3);
        chk("b_pop_ready", o_ready, 1);
        chk("b_pop_head", o_data, 8'hB1);
        i_data  = 8'hB5;
        step();
        chk("b_pp_count", o_count, 3);
        chk("b_pp_head", o_data, 8'hB2);
        chk("b_pp_ready", o_ready, 1);

        // 5. flush with a push offered in the same cycle
        flush   = 1'b1;
        i_ready = 1'b0;
        i_data  = 8'hC0;
        step();
        flush   = 1'b0;
        chk("flush_count", o_count, 0);
        chk("flush_valid", o_valid, 0);
        chk("flush_ready", o_ready, 1);
        chk("flush_afull", o_almost_full, 0);
        i_data  = 8'h5A;
        step();
        chk("post_flush_head", o_data, 8'h5A);
        chk("post_flush_count", o_count, 1);
        i_valid = 1'b0;
        i_ready = 1'b1;
        step();
        chk("post_flush_empty", o_valid, 0);
        i_ready = 1'b0;

        // 6. DEPTH=3 wrap against a queue model
        pv = 12'b1110_1101_1111;
        pr = 12'b1011_1011_1000;
        for (int i = 0; i < 12; i++) begin
            dv   = 8'(8'h30 + i);
            v3   = pv[i];
            r3   = pr[i];
            d3   = dv;
            psh  = v3 && rdy3;
            pp   = vo3 && r3;
            step();
            if (pp) begin
                void'(sb.pop_front());
            end
            if (psh) begin
                sb.push_back(dv);
            end
            chk("d3_count", cnt3, sb.size());
            chk("d3_valid", vo3, sb.size() != 0);
            chk("d3_ready", rdy3, sb.size() < 3);
            if (sb.size() != 0) begin
                chk("d3_data", q3, sb[0]);
            end
        end

        // mid-stream asynchronous reset on the DEPTH=3 instance
        v3 = 1'b1;
        r3 = 1'b0;
        d3 = 8'h66;
        step();
        #2;
        rst3_n = 1'b0;
        #1;
        chk("d3_rst_valid", vo3, 0);
        chk("d3_rst_ready", rdy3, 0);
        chk("d3_rst_count", cnt3, 0);
        chk("d3_rst_data", q3, 0);
        chk("d3_rst_afull", af3, 0);
        v3 = 1'b0;
        #1;
        rst3_n = 1'b1;
        sb.delete();
        step();
        chk("d3_rec_ready", rdy3, 1);
        chk("d3_rec_valid", vo3, 0);
        v3 = 1'b1;
        d3 = 8'h77;
        step();
        v3 = 1'b0;
        chk("d3_rec_head", q3, 8'h77);
        chk("d3_rec_count", cnt3, 1);
        r3 = 1'b1;
        step();
        chk("d3_rec_empty", vo3, 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
